// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared FSM encoding and calibrator status bit indices
package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_PROG    = 3'd2,
    S_CAL     = 3'd3,
    S_GRANTED = 3'd4,
    S_REL     = 3'd5
  } state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_LOCK = 1;
  localparam int STAT_FAIL = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request strictly after the pointer
module rr_arbiter
  import clock_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_sched.sv
// rtl/clock_sched.sv - shares one calibrated oscillator among N_REQ requesters
module clock_sched
  import clock_pkg::*;
#(
  parameter int          N_REQ      = 4,
  parameter logic [31:0] REF_WINDOW = 32'd1000,
  parameter int          RST_CYC    = 4,
  parameter int          TIMEOUT    = 65535
) (
  input  logic                  ref_clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [9*N_REQ-1:0]    req_init,
  input  logic [32*N_REQ-1:0]   req_counter,
  input  logic [N_REQ-1:0]      req_release,
  output logic [N_REQ-1:0]      grant,
  output logic                  grant_locked,
  output logic [N_REQ-1:0]      req_err,
  output logic                  cal_resetn,
  output logic [8:0]            cal_init,
  output logic [31:0]           cal_counter,
  output logic [31:0]           cal_ref_counter,
  input  logic [2:0]            cal_status
);

  localparam int          PW        = idx_w(N_REQ);
  localparam logic [31:0] PROG_LAST = 32'(RST_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);

  state_t            r_state, w_next_state;
  logic [PW-1:0]     r_rr_ptr, r_winner, w_winner_next, w_arb_idx;
  logic [N_REQ-1:0]  w_arb_grant, w_grant_next, w_err_next;
  logic              w_arb_valid, w_skip, w_timeout, w_lock_next, w_latch_cfg;
  logic [N_REQ-1:0]  r_grant, r_err;
  logic              r_grant_locked, r_lock, r_cal_resetn;
  logic [8:0]        r_cal_init;
  logic [31:0]       r_cal_counter, r_prog_cnt, r_to_cnt;
  logic              w_unused_busy;

  logic [8:0]  w_init_arr [N_REQ];
  logic [31:0] w_cnt_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_init_arr[g] = req_init[9*g +: 9];
    assign w_cnt_arr[g]  = req_counter[32*g +: 32];
  end

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_arb_grant[k]) w_arb_idx = PW'(k);
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_winner_next = r_winner;
    w_lock_next   = r_lock;
    w_err_next    = r_err;
    w_latch_cfg   = 1'b0;
    w_skip        = r_lock && (w_init_arr[w_arb_idx] == r_cal_init) &&
                    (w_cnt_arr[w_arb_idx] == r_cal_counter);
    w_timeout     = (r_to_cnt >= TO_LAST);
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_next_state = S_ARB;
      end
      S_ARB: begin
        if (!w_arb_valid) begin
          w_next_state = S_IDLE;
        end else begin
          w_winner_next = w_arb_idx;
          if (w_skip) begin
            w_next_state = S_GRANTED;
          end else begin
            w_next_state = S_PROG;
            w_lock_next  = 1'b0;
            w_latch_cfg  = 1'b1;
          end
        end
      end
      S_PROG: begin
        if (r_prog_cnt >= PROG_LAST) w_next_state = S_CAL;
      end
      S_CAL: begin
        // Fail has priority over a simultaneous lock report.
        if (cal_status[STAT_FAIL] || (!cal_status[STAT_LOCK] && w_timeout)) begin
          w_next_state         = S_REL;
          w_err_next[r_winner] = 1'b1;
        end else if (cal_status[STAT_LOCK]) begin
          w_next_state = S_GRANTED;
          w_lock_next  = 1'b1;
        end
      end
      S_GRANTED: begin
        if (!cal_status[STAT_LOCK]) w_lock_next = 1'b0;
        if (req_release[r_winner] || !req_valid[r_winner]) w_next_state = S_REL;
      end
      S_REL: begin
        w_next_state = (|req_valid) ? S_ARB : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_next_state == S_GRANTED && r_state != S_GRANTED)
      w_err_next[w_winner_next] = 1'b0;
    w_grant_next = '0;
    if (w_next_state == S_GRANTED) w_grant_next[w_winner_next] = 1'b1;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_rr_ptr       <= PTR_RST;
      r_winner       <= '0;
      r_lock         <= 1'b0;
      r_err          <= '0;
      r_cal_init     <= '0;
      r_cal_counter  <= '0;
      r_grant        <= '0;
      r_grant_locked <= 1'b0;
      r_cal_resetn   <= 1'b0;
      r_prog_cnt     <= '0;
      r_to_cnt       <= '0;
    end else begin
      r_winner       <= w_winner_next;
      if (r_state == S_ARB && w_arb_valid) r_rr_ptr <= w_arb_idx;
      r_lock         <= w_lock_next;
      r_err          <= w_err_next;
      if (w_latch_cfg) begin
        r_cal_init    <= w_init_arr[w_arb_idx];
        r_cal_counter <= w_cnt_arr[w_arb_idx];
      end
      r_grant        <= w_grant_next;
      r_grant_locked <= (w_next_state == S_GRANTED) && w_lock_next;
      r_cal_resetn   <= (w_next_state != S_PROG);
      r_prog_cnt     <= (r_state == S_PROG) ? r_prog_cnt + 32'd1 : 32'd0;
      if (r_state == S_CAL) r_to_cnt <= (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 32'd1;
      else                  r_to_cnt <= '0;
    end
  end

  assign w_unused_busy   = cal_status[STAT_BUSY];
  assign grant           = r_grant;
  assign grant_locked    = r_grant_locked;
  assign req_err         = r_err;
  assign cal_resetn      = r_cal_resetn;
  assign cal_init        = r_cal_init;
  assign cal_counter     = r_cal_counter;
  assign cal_ref_counter = REF_WINDOW;

endmodule

// File: tb/tb_clock_sched.sv
// tb/tb_clock_sched.sv - directed scoreboard bench for clock_sched with a calibrator model
module tb_clock_sched;

  logic         ref_clk, reset;
  logic [3:0]   req_valid, req_release, grant, req_err;
  logic [35:0]  req_init;
  logic [127:0] req_counter;
  logic         grant_locked, cal_resetn;
  logic [8:0]   cal_init;
  logic [31:0]  cal_counter, cal_ref_counter;
  logic [2:0]   cal_status;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q [$];
  int  m_mode = 0;
  int  m_lat  = 20;
  int  m_cnt  = 0;
  bit  mon_en = 0;

  clock_sched #(.N_REQ(4), .REF_WINDOW(32'd1000), .RST_CYC(4), .TIMEOUT(100)) dut (
    .ref_clk(ref_clk), .reset(reset), .req_valid(req_valid), .req_init(req_init),
    .req_counter(req_counter), .req_release(req_release), .grant(grant),
    .grant_locked(grant_locked), .req_err(req_err), .cal_resetn(cal_resetn),
    .cal_init(cal_init), .cal_counter(cal_counter), .cal_ref_counter(cal_ref_counter),
    .cal_status(cal_status)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $error("FAIL %s: observed grant %0h with empty scoreboard", tag, grant);
    end else begin
      e = exp_q.pop_front();
      check(tag, grant, e);
    end
  endtask

  task automatic wait_grant(input int budget, output int cyc);
    cyc = 1;
    while (grant == 4'b0 && cyc < budget) begin
      @(negedge ref_clk);
      cyc++;
    end
    if (grant == 4'b0) begin
      n_checks++; n_fail++;
      $error("FAIL wait_grant: observed no grant in %0d cycles, required a grant", cyc);
    end
  endtask

  task automatic wait_resetn(input logic lvl, input int budget);
    int c = 0;
    while (cal_resetn !== lvl && c < budget) begin
      @(negedge ref_clk);
      c++;
    end
    if (cal_resetn !== lvl) begin
      n_checks++; n_fail++;
      $error("FAIL wait_resetn: observed %0b expected %0b", cal_resetn, lvl);
    end
  endtask

  // Calibrator model: mode 0 locks, mode 1 fails, mode 2 stays busy, m_lat cycles after resetn rises.
  initial begin
    cal_status = 3'b000;
    forever begin
      @(negedge ref_clk);
      if (cal_resetn !== 1'b1) begin
        m_cnt      = 0;
        cal_status = 3'b000;
      end else begin
        if (m_cnt < 1000000) m_cnt++;
        case (m_mode)
          0:       cal_status = (m_cnt >= m_lat) ? 3'b010 : 3'b001;
          1:       cal_status = (m_cnt >= m_lat) ? 3'b110 : 3'b001;
          default: cal_status = 3'b001;
        endcase
      end
    end
  end

  always @(negedge ref_clk) begin
    if (mon_en) check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
  end

  initial begin
    int cyc;
    int lowcnt;
    bit gseen;
    reset = 1'b1; req_valid = '0; req_release = '0; req_init = '0; req_counter = '0;
    repeat (3) @(negedge ref_clk);
    check("rst_grant", grant, 0);
    check("rst_grant_locked", grant_locked, 0);
    check("rst_req_err", req_err, 0);
    check("rst_cal_resetn", cal_resetn, 0);
    check("rst_cal_init", cal_init, 0);
    check("rst_cal_counter", cal_counter, 0);
    check("ref_counter", cal_ref_counter, 32'd1000);
    mon_en = 1;
    reset = 1'b0;
    repeat (2) @(negedge ref_clk);

    // Single requester, full calibration.
    req_init[8:0] = 9'h011; req_counter[31:0] = 32'd500; req_valid = 4'b0001;
    @(negedge ref_clk);
    check("arb_cycle_resetn", cal_resetn, 1);
    @(negedge ref_clk);
    check("prog_latency", cal_resetn, 0);
    lowcnt = 0;
    for (int i = 0; i < 50 && cal_resetn == 1'b0; i++) begin
      lowcnt++;
      @(negedge ref_clk);
    end
    check("rst_pulse_len", lowcnt, 4);
    check("cal_init_a", cal_init, 9'h011);
    check("cal_counter_a", cal_counter, 32'd500);
    exp_q.push_back(4'b0001);
    wait_grant(100, cyc);
    check("lock_to_grant", cyc, 21);
    sb_check("grant_a");
    check("locked_a", grant_locked, 1);
    repeat (3) @(negedge ref_clk);
    check("grant_a_hold", grant, 4'b0001);
    req_release = 4'b0001; req_valid = 4'b0000;
    @(negedge ref_clk);
    req_release = 4'b0000;
    check("rel_grant_a", grant, 0);
    repeat (3) @(negedge ref_clk);

    // Requester 2 calibrates, releases, then re-requests with the same settings.
    req_init[26:18] = 9'h155; req_counter[95:64] = 32'd777; req_valid = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(100, cyc);
    sb_check("grant_b1");
    check("cal_init_b", cal_init, 9'h155);
    req_release = 4'b0100; req_valid = 4'b0000;
    @(negedge ref_clk);
    req_release = 4'b0000;
    repeat (3) @(negedge ref_clk);
    req_valid = 4'b0100;
    exp_q.push_back(4'b0100);
    @(negedge ref_clk);
    check("skip_arb_grant", grant, 0);
    check("skip_arb_resetn", cal_resetn, 1);
    @(negedge ref_clk);
    sb_check("skip_grant");
    check("skip_locked", grant_locked, 1);
    check("skip_no_prog", cal_resetn, 1);
    req_release = 4'b0100; req_valid = 4'b0000;
    @(negedge ref_clk);
    req_release = 4'b0000;
    repeat (3) @(negedge ref_clk);

    // Calibration failure on requester 3, then requester 1 is arbitrated.
    m_mode = 1; m_lat = 5;
    req_init[17:9] = 9'h0a2;  req_counter[63:32]  = 32'd300;
    req_init[35:27] = 9'h1f3; req_counter[127:96] = 32'd900;
    req_valid = 4'b1010;
    gseen = 0; cyc = 0;
    while (req_err == 4'b0 && cyc < 100) begin
      @(negedge ref_clk);
      cyc++;
      if (grant != 4'b0) gseen = 1;
    end
    check("fail_err", req_err, 4'b1000);
    check("fail_no_grant", 32'(gseen), 0);
    check("fail_rel_grant", grant, 0);
    m_mode = 0; m_lat = 20;
    exp_q.push_back(4'b0010);
    wait_grant(100, cyc);
    sb_check("grant_after_fail");
    check("err_kept", req_err, 4'b1000);
    check("cal_init_c", cal_init, 9'h0a2);
    req_release = 4'b0010; req_valid = 4'b1000;
    @(negedge ref_clk);
    req_release = 4'b0000;
    exp_q.push_back(4'b1000);
    wait_grant(100, cyc);
    sb_check("grant_r3");
    check("err_cleared", req_err, 0);
    req_release = 4'b0001;
    @(negedge ref_clk);
    req_release = 4'b0000;
    @(negedge ref_clk);
    check("other_release_ignored", grant, 4'b1000);
    req_release = 4'b1000; req_valid = 4'b0000;
    @(negedge ref_clk);
    req_release = 4'b0000;
    repeat (3) @(negedge ref_clk);

    // All four requesting, each holds 10 granted cycles.
    req_init = {9'h108, 9'h084, 9'h042, 9'h021};
    req_counter = {32'd4444, 32'd3333, 32'd2222, 32'd1111};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_grant(200, cyc);
      sb_check("rr_order");
      repeat (9) @(negedge ref_clk);
      check("rr_hold10", 32'($onehot(grant)), 1);
      req_release = grant;
      if (r == 4) req_valid = 4'b0000;
      @(negedge ref_clk);
      req_release = 4'b0000;
    end
    repeat (3) @(negedge ref_clk);

    // Never locks: timeout after 100 CAL cycles, then REL.
    m_mode = 2;
    req_init[17:9] = 9'h0c3; req_counter[63:32] = 32'd5555; req_valid = 4'b0010;
    wait_resetn(1'b0, 10);
    wait_resetn(1'b1, 10);
    cyc = 1;
    while (req_err[1] == 1'b0 && cyc < 300) begin
      @(negedge ref_clk);
      cyc++;
    end
    check("timeout_cycle", cyc, 101);
    check("timeout_no_grant", grant, 0);
    m_mode = 0;
    @(negedge ref_clk);
    check("timeout_arb_resetn", cal_resetn, 1);
    @(negedge ref_clk);
    check("timeout_reprog", cal_resetn, 0);
    exp_q.push_back(4'b0010);
    wait_grant(100, cyc);
    sb_check("grant_after_timeout");
    check("err_cleared_timeout", req_err, 0);

    // Reset pulse during GRANTED.
    reset = 1'b1; req_valid = 4'b1111;
    @(negedge ref_clk);
    reset = 1'b0;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_locked", grant_locked, 0);
    check("mid_rst_err", req_err, 0);
    check("mid_rst_resetn", cal_resetn, 0);
    check("mid_rst_init", cal_init, 0);
    check("mid_rst_counter", cal_counter, 0);
    exp_q.push_back(4'b0001);
    wait_grant(100, cyc);
    sb_check("grant_after_reset");
    req_valid = 4'b0000;
    repeat (3) @(negedge ref_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
